// File: rtl/reg_port_sequencer.sv
// reg_port_sequencer: writeback FIFO plus read arbiter driving the shared register-bank port.
// Optional read bypass from queued writes: define REGSEQ_BYPASS_EN.
module reg_port_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wb_valid,
  output logic       wb_ready,
  input  logic [1:0] wb_rd,
  input  logic [7:0] wb_data,
  input  logic       rd_req,
  output logic       rd_ready,
  input  logic [1:0] rd_rs,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       WR,
  output logic [1:0] rs,
  output logic [7:0] data,
  input  logic [7:0] regVal
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef REGSEQ_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_READ,
    SLOT_WRITE
  } slot_t;

  logic [1:0]    q_rd   [DEPTH];
  logic [7:0]    q_data [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;

  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic       hazard;
  logic       bank_rd;
  logic [7:0] byp_data;
  slot_t      slot;

  logic       s1_valid;
  logic       s1_byp;
  logic [7:0] s1_data;
  logic       s2_valid;
  logic [7:0] s2_data;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign wb_ready = !full;
  assign push     = wb_valid & !full;

  // Walk oldest to youngest so the last match is the youngest writer.
  always_comb begin
    hazard   = 1'b0;
    byp_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count && q_rd[head + AW'(i)] == rd_rs) begin
        hazard   = 1'b1;
        byp_data = q_data[head + AW'(i)];
      end
    end
  end

  assign rd_ready = rd_req & !full & (BYPASS | !hazard);
  assign bank_rd  = rd_ready & !(BYPASS & hazard);

  always_comb begin
    slot = SLOT_IDLE;
    if (full)
      slot = SLOT_WRITE;
    else if (bank_rd)
      slot = SLOT_READ;
    else if (!empty)
      slot = SLOT_WRITE;
    else
      slot = SLOT_IDLE;
  end

  assign pop = (slot == SLOT_WRITE);

  always_ff @(posedge clock) begin
    if (push) begin
      q_rd[tail]   <= wb_rd;
      q_data[tail] <= wb_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      WR       <= 1'b0;
      rs       <= '0;
      data     <= '0;
      s1_valid <= 1'b0;
      s1_byp   <= 1'b0;
      s1_data  <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (push)
        tail <= tail + AW'(1);
      if (pop)
        head <= head + AW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);

      WR <= (slot == SLOT_WRITE);
      case (slot)
        SLOT_WRITE: begin
          rs   <= q_rd[head];
          data <= q_data[head];
        end
        SLOT_READ: rs <= rd_rs;
        default: ;
      endcase

      // regVal is only stable late in the cycle after rs is driven.
      s1_valid <= rd_ready;
      s1_byp   <= BYPASS & hazard;
      s1_data  <= byp_data;
      s2_valid <= s1_valid;
      s2_data  <= s1_byp ? s1_data : regVal;
      rd_valid <= s2_valid;
      if (s2_valid)
        rd_data <= s2_data;
    end
  end

endmodule

// File: tb/tb_reg_port_sequencer.sv
// tb_reg_port_sequencer: random and directed traffic against a program-order register model.
// Build with REGSEQ_BYPASS_EN defined to exercise the bypass variant.
module tb_reg_port_sequencer;
  localparam int DEPTH = 4;
`ifdef REGSEQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       wb_valid = 1'b0;
  logic       wb_ready;
  logic [1:0] wb_rd = '0;
  logic [7:0] wb_data = '0;
  logic       rd_req = 1'b0;
  logic       rd_ready;
  logic [1:0] rd_rs = '0;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       WR;
  logic [1:0] rs;
  logic [7:0] data;
  logic [7:0] regVal = '0;

  always #5 clock = ~clock;

  reg_port_sequencer #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rd(wb_rd), .wb_data(wb_data),
    .rd_req(rd_req), .rd_ready(rd_ready), .rd_rs(rd_rs),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .WR(WR), .rs(rs), .data(data), .regVal(regVal)
  );

  // Bank: commits on posedge, read data only meaningful after negedge.
  logic [7:0] bank [4] = '{8'h10, 8'h20, 8'h30, 8'h40};
  always @(posedge clock) if (WR) bank[rs] <= data;
  always begin
    @(posedge clock);
    #2 regVal = 8'($urandom);
    @(negedge clock);
    regVal = bank[rs];
  end

  typedef struct packed {
    logic [1:0] r;
    logic [7:0] d;
  } wr_t;
  typedef struct {
    int         due;
    logic [7:0] v;
  } rdx_t;

  wr_t        q[$];
  rdx_t       rq[$];
  logic [7:0] arch [4];
  logic [1:0] last_rs;
  logic [7:0] last_data;
  int         cyc;
  int         total;
  int         bad;

  bit         p_push, p_acc, p_full, p_hz;
  wr_t        p_w;
  logic [1:0] p_rs;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit in_q(input logic [1:0] r);
    foreach (q[i]) if (q[i].r == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic clear_pending();
    p_push = 0; p_acc = 0; p_full = 0; p_hz = 0;
  endtask

  // Apply what happened at the edge just passed and check registered outputs.
  task automatic edge_update();
    bit  bank_read;
    wr_t w;
    cyc++;
    bank_read = p_acc && !(BYP && p_hz);
    if (q.size() > 0 && (p_full || !bank_read)) begin
      w = q.pop_front();
      check("wr_pulse", WR, 1);
      check("wr_rs", rs, w.r);
      check("wr_data", data, w.d);
      last_rs = w.r;
      last_data = w.d;
    end else if (bank_read) begin
      check("rd_slot_wr", WR, 0);
      check("rd_slot_rs", rs, p_rs);
      check("rd_slot_data", data, last_data);
      last_rs = p_rs;
    end else begin
      check("idle_wr", WR, 0);
      check("idle_rs", rs, last_rs);
      check("idle_data", data, last_data);
    end
    if (rq.size() > 0 && rq[0].due == cyc) begin
      check("rd_valid", rd_valid, 1);
      check("rd_data", rd_data, rq[0].v);
      void'(rq.pop_front());
    end else begin
      check("rd_valid_lo", rd_valid, 0);
    end
    if (p_acc) rq.push_back('{cyc + 2, arch[p_rs]});
    if (p_push) begin
      q.push_back(p_w);
      arch[p_w.r] = p_w.d;
    end
    clear_pending();
  endtask

  task automatic cycle(input bit wv, input logic [1:0] wr, input logic [7:0] wd,
                       input bit rv, input logic [1:0] rr,
                       output bit pushed, output bit accepted);
    bit e_wbr, e_rdr, hz;
    wb_valid = wv; wb_rd = wr; wb_data = wd;
    rd_req = rv; rd_rs = rr;
    #1;
    hz = in_q(rr);
    e_wbr = q.size() < DEPTH;
    e_rdr = rv && e_wbr && (BYP || !hz);
    check("wb_ready", wb_ready, e_wbr);
    check("rd_ready", rd_ready, e_rdr);
    p_full = !e_wbr;
    p_push = wv && e_wbr;
    p_acc = e_rdr;
    p_hz = hz;
    p_rs = rr;
    p_w = '{wr, wd};
    pushed = p_push;
    accepted = p_acc;
    @(posedge clock);
    #1;
    edge_update();
  endtask

  task automatic idle(input int n);
    bit a, b;
    repeat (n) cycle(0, 2'd0, 8'd0, 0, 2'd0, a, b);
  endtask

  task automatic do_reset(input int n);
    wb_valid = 0; rd_req = 0; reset = 1;
    repeat (n) begin
      @(posedge clock);
      #1;
      cyc++;
      check("rst_wr", WR, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_wb_ready", wb_ready, 1);
    end
    check("rst_rs", rs, 0);
    check("rst_data", data, 0);
    check("rst_rd_data", rd_data, 0);
    reset = 0;
    q.delete();
    rq.delete();
    last_rs = '0;
    last_data = '0;
    foreach (arch[i]) arch[i] = bank[i];
    clear_pending();
  endtask

  // Hold a write until taken, bounded.
  task automatic push_one(input logic [1:0] r, input logic [7:0] d);
    bit pu, ac;
    int n;
    n = 0;
    pu = 0;
    while (!pu && n < 20) begin
      cycle(1, r, d, 0, 2'd0, pu, ac);
      n++;
    end
    if (!pu) check("push_timeout", 0, 1);
  endtask

  // Hold a read until accepted, bounded, then let it complete.
  task automatic read_one(input logic [1:0] r, input int max_wait);
    bit pu, ac;
    int n;
    n = 0;
    ac = 0;
    while (!ac && n < 20) begin
      cycle(0, 2'd0, 8'd0, 1, r, pu, ac);
      n++;
    end
    if (!ac) check("read_timeout", 0, 1);
    check("read_wait", 32'(n <= max_wait), 1);
    idle(3);
  endtask

  initial begin
    bit         pu, ac, hv, hr;
    logic [1:0] wr_r, rr_r;
    logic [7:0] wd_r;
    total = 0;
    bad = 0;
    cyc = 0;
    last_rs = '0;
    last_data = '0;
    clear_pending();

    do_reset(2);
    idle(5);
    check("idle5_wr", WR, 0);
    check("idle5_rs", rs, 0);
    check("idle5_data", data, 0);
    check("idle5_rd_valid", rd_valid, 0);
    check("idle5_wb_ready", wb_ready, 1);

    cycle(1, 2'b10, 8'h5A, 0, 2'd0, pu, ac);
    idle(1);
    check("t0_wr", WR, 1);
    check("t0_rs", rs, 2'b10);
    check("t0_data", data, 8'h5A);
    idle(1);
    read_one(2'b10, 1);

    for (int i = 0; i < 7; i++)
      cycle(i < 4, 2'b11, 8'(8'hA0 + i), 1, 2'b01, pu, ac);
    idle(5);

    push_one(2'b01, 8'h33);
    read_one(2'b01, BYP ? 1 : 2);

    push_one(2'b00, 8'h11);
    push_one(2'b00, 8'h22);
    read_one(2'b00, BYP ? 1 : 3);

    for (int i = 0; i < 3; i++)
      cycle(1, 2'b00, 8'(8'hC0 + i), 1, 2'b11, pu, ac);
    do_reset(1);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("post_rst_wr", WR, 0);
    end

    hv = 0;
    hr = 0;
    wr_r = '0;
    rr_r = '0;
    wd_r = '0;
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        do_reset(2);
        hv = 0;
        hr = 0;
      end
      if (!hv) begin
        hv = $urandom_range(0, 99) < 55;
        wr_r = 2'($urandom);
        wd_r = 8'($urandom);
      end
      if (!hr) begin
        hr = $urandom_range(0, 99) < 45;
        rr_r = 2'($urandom);
      end
      cycle(hv, wr_r, wd_r, hr, rr_r, pu, ac);
      if (pu) hv = 0;
      if (ac) hr = 0;
    end

    idle(DEPTH + 6);
    for (int i = 0; i < 4; i++)
      check($sformatf("bank%0d", i), bank[i], arch[i]);
    check("rq_drained", rq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
